// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Round-robin arbiter that shares one AXI-lite-style DRAM port among NREQ
//   clients. Each client issues single-word read or write requests with a
//   valid/grant handshake. Exactly one DRAM transaction is in flight at a time,
//   and the granted client receives a one-cycle completion pulse.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid/req_write       per-client request valid and direction (1=write)
//   req_addr/req_wdata        per-client address/data, client i at [i*W +: W]
//   req_grant                 one-hot, request accepted this cycle (IDLE only)
//   rsp_valid                 one-hot completion pulse to the granted client
//   rsp_rdata/rsp_err         read data (0 for writes) and error flag
//   busy                      high in every state except IDLE
//   ar_*/r_*/aw_*/w_*/b_*     DRAM channels; outputs decode from registers only
module dram_arbiter #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_grant,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic                     busy,
   output logic                     ar_valid,
   output logic [ADDR_W-1:0]        ar_addr,
   input  logic                     ar_ready,
   input  logic                     r_valid,
   output logic                     r_ready,
   input  logic [DATA_W-1:0]        r_data,
   input  logic [1:0]               r_resp,
   output logic                     aw_valid,
   output logic [ADDR_W-1:0]        aw_addr,
   input  logic                     aw_ready,
   output logic                     w_valid,
   output logic [DATA_W-1:0]        w_data,
   input  logic                     w_ready,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [1:0]               b_resp
);

   localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_RSP  = 3'd6;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

   logic [2:0]        state;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   id;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              err;

   logic              found;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   scan_idx;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Round-robin scan: start one past the last served client and wrap, so the
   // first valid client found in that order wins.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         scan_idx = ID_W'((32'(last) + k) % NREQ);
         if (!found && req_valid[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
         end
      end
   end

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick == ID_W'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         last  <= LAST_RST;
         id    <= '0;
         wr    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  id    <= pick;
                  wr    <= sel_write;
                  addr  <= sel_addr;
                  wdata <= sel_wdata;
                  state <= sel_write ? S_AW : S_AR;
               end
            end
            S_AR: if (ar_ready) state <= S_R;
            S_R: begin
               if (r_valid) begin
                  rdata <= r_data;
                  err   <= (r_resp != 2'b00);
                  state <= S_RSP;
               end
            end
            S_AW: if (aw_ready) state <= S_W;
            S_W:  if (w_ready)  state <= S_B;
            S_B: begin
               if (b_valid) begin
                  rdata <= '0;
                  err   <= (b_resp != 2'b00);
                  state <= S_RSP;
               end
            end
            S_RSP: begin
               last  <= id;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Grant is the only combinational client-side output; every DRAM-side
   // output is a pure decode of registered state and latched fields.
   always_comb begin
      req_grant = '0;
      rsp_valid = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_grant[i] = (state == S_IDLE) && found && (pick == ID_W'(i));
         rsp_valid[i] = (state == S_RSP) && (id == ID_W'(i));
      end
   end

   always_comb begin
      busy      = (state != S_IDLE);
      rsp_rdata = (state == S_RSP) ? rdata : '0;
      rsp_err   = (state == S_RSP) && err;
      ar_valid  = (state == S_AR);
      ar_addr   = addr;
      r_ready   = (state == S_R);
      aw_valid  = (state == S_AW);
      aw_addr   = addr;
      w_valid   = (state == S_W);
      w_data    = wdata;
      b_ready   = (state == S_B);
   end

   logic unused_wr;
   assign unused_wr = wr;

endmodule
